// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and helpers for the PPU back end.
//
// Contents:
//   FB_WORD_W       - framebuffer data word width ({right, left} BGR555 pair)
//   FB_ENTRY_ADDR_W - word-address width carried in a queued entry ({v_line, x})
//   dot_step_e      - names for the 4-phase dot counter shared with the mixer
//   fb_entry_type   - one queued framebuffer write (address + data)
//   scale_channel() - master-brightness scaling of one 5-bit colour channel
package ppu_pkg;

  localparam int FB_WORD_W       = 30;
  localparam int FB_ENTRY_ADDR_W = 16;
  localparam int CH_W            = 5;
  localparam int PIX_W           = 15;

  typedef enum logic [1:0] {
    STEP_CAPTURE = 2'd0,
    STEP_1       = 2'd1,
    STEP_2       = 2'd2,
    STEP_3       = 2'd3
  } dot_step_e;

  typedef struct packed {
    logic [FB_ENTRY_ADDR_W-1:0] addr;
    logic [FB_WORD_W-1:0]       data;
  } fb_entry_type;

  // (c * (b + 1)) >> 4 with a 9-bit product: 31 * 16 = 496 still fits, and
  // b = 15 returns c unchanged.
  function automatic logic [CH_W-1:0] scale_channel(input logic [CH_W-1:0] c,
                                                    input logic [3:0]      b);
    logic [8:0] prod;
    prod = 9'(c) * (9'(b) + 9'd1);
    return prod[8:4];
  endfunction

endpackage

// File: rtl/ppu_brightness_scaler.sv
// ppu_brightness_scaler: applies INIDISP master brightness and forced blank to
// one BGR555 pixel. Purely combinational.
//
// Ports:
//   color_in    in  15  pixel from the mixer (BGR555)
//   brightness  in  4   master brightness, 0 = black, 15 = unchanged
//   force_blank in  1   forced blank, output black
//   color_out   out 15  scaled pixel (BGR555)
module ppu_brightness_scaler
  import ppu_pkg::*;
(
  input  logic [14:0] color_in,
  input  logic [3:0]  brightness,
  input  logic        force_blank,
  output logic [14:0] color_out
);

  // NOTE: combinational blocks assign every output a default first so no
  // path through the block can leave a value held, which would infer a latch.
  always_comb begin
    color_out = '0;
    if (!force_blank && (brightness != 4'd0)) begin
      for (int ch = 0; ch < 3; ch++) begin
        color_out[ch*CH_W +: CH_W] = scale_channel(color_in[ch*CH_W +: CH_W], brightness);
      end
    end
  end

endmodule

// File: rtl/ppu_screen_writer.sv
// ppu_screen_writer: captures the mixer's left/right pixel pair once per
// visible dot, applies master brightness / forced blank, and queues the
// result for the external framebuffer so the dot pipeline never waits on
// memory. When the queue is full and cannot drain, dots are dropped and
// reported through a sticky overflow flag.
//
// Build option:
//   PPU_SCREEN_WRITER_DROP_CNT_EN  defined: drop_count is a 16-bit
//                                  saturating count of dropped dots.
//                                  undefined: drop_count reads 16'h0.
//
// Ports:
//   clk          in  1          system clock
//   reset        in  1          asynchronous, active-high reset
//   step         in  2          PPU dot phase; capture happens at phase 0
//   dot_active   in  1          current dot is visible (phase 0 only)
//   line_start   in  1          pulse at start of a visible line, clears x
//   v_line       in  8          current visible line
//   color_left   in  15         mixer left pixel (BGR555)
//   color_right  in  15         mixer right pixel (BGR555)
//   brightness   in  4          INIDISP master brightness
//   force_blank  in  1          INIDISP forced blank
//   fb_wvalid    out 1          write request valid (queue non-empty)
//   fb_wready    in  1          framebuffer accepts the head entry
//   fb_waddr     out FB_ADDR_W  word address {v_line, x}
//   fb_wdata     out 30         {right, left}
//   ovf_clear    in  1          clears the overflow flag
//   overflow     out 1          sticky: at least one dot was dropped
//   drop_count   out 16         dropped-dot counter
//
// Latency: capture edge loads S1, next edge S2, next edge writes the queue;
// fb_wvalid is high after that third edge.
module ppu_screen_writer
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FB_ADDR_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           step,
  input  logic                 dot_active,
  input  logic                 line_start,
  input  logic [7:0]           v_line,
  input  logic [14:0]          color_left,
  input  logic [14:0]          color_right,
  input  logic [3:0]           brightness,
  input  logic                 force_blank,
  output logic                 fb_wvalid,
  input  logic                 fb_wready,
  output logic [FB_ADDR_W-1:0] fb_waddr,
  output logic [29:0]          fb_wdata,
  input  logic                 ovf_clear,
  output logic                 overflow,
  output logic [15:0]          drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Dot capture and x counter
  // ---------------------------------------------------------------------------
  logic       capture;
  logic [7:0] x;
  logic [7:0] x_cap;

  assign capture = (dot_step_e'(step) == STEP_CAPTURE) && dot_active;
  // A line_start on the capture clock wins: that dot is x = 0.
  assign x_cap   = line_start ? 8'd0 : x;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= 8'd0;
    end else if (capture) begin
      x <= x_cap + 8'd1;   // 255 -> 0 wraps silently
    end else if (line_start) begin
      x <= 8'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Brightness
  // ---------------------------------------------------------------------------
  logic [14:0] left_scaled;
  logic [14:0] right_scaled;

  ppu_brightness_scaler u_scale_left (
    .color_in    (color_left),
    .brightness  (brightness),
    .force_blank (force_blank),
    .color_out   (left_scaled)
  );

  ppu_brightness_scaler u_scale_right (
    .color_in    (color_right),
    .brightness  (brightness),
    .force_blank (force_blank),
    .color_out   (right_scaled)
  );

  // ---------------------------------------------------------------------------
  // Two-stage pipeline into the queue
  // ---------------------------------------------------------------------------
  logic         s1_valid;
  fb_entry_type s1_entry;
  logic         s2_valid;
  fb_entry_type s2_entry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_entry <= '0;
      s2_valid <= 1'b0;
      s2_entry <= '0;
    end else begin
      s1_valid <= capture;
      if (capture) begin
        s1_entry.addr <= {v_line, x_cap};
        s1_entry.data <= {right_scaled, left_scaled};
      end
      s2_valid <= s1_valid;
      s2_entry <= s1_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Queue: register array with pointers one bit wider than the index, so
  // equal pointers mean empty and pointers differing only in the top bit
  // mean full.
  // ---------------------------------------------------------------------------
  fb_entry_type     mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  fb_entry_type     head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = fb_wvalid && fb_wready;
  // A pop on the same edge frees the slot, so a full queue still accepts.
  assign push  = s2_valid && (!full || pop);
  assign drop  = s2_valid && full && !pop;

  // NOTE: the storage array has no reset; a slot is only read once the write
  // pointer has passed it, and the outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= s2_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Head is read straight from storage; it only moves on a pop, so address
  // and data hold while the framebuffer stalls.
  assign head      = mem[rd_ptr[PTR_W-1:0]];
  assign fb_wvalid = !empty;
  assign fb_waddr  = fb_wvalid ? FB_ADDR_W'(head.addr) : '0;
  assign fb_wdata  = fb_wvalid ? head.data : '0;

  // ---------------------------------------------------------------------------
  // Overflow reporting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;          // a drop beats a coincident clear
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

`ifdef PPU_SCREEN_WRITER_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= 16'h0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign drop_count = 16'h0;
`endif

endmodule
